alu_control_sequencer: RTL and testbench

- Hardwired control unit that drives the datapath's control strobes for instruction fetch and register-register ALU execution.
- It produces the same per-cycle signal pattern that bench code currently hand-sequences (T0..T6), decoded from the datapath's IR contents.
- It sits beside the datapath, with outputs wired one-to-one to datapath control inputs, and handles a memory-ready wait during fetch.

---
 rtl/alu_control_sequencer_if.sv | 41 ++++
 rtl/alu_control_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_alu_control_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_sequencer_if.sv
// Control-strobe bus between the hardwired sequencer (master) and the datapath (slave).
// Carries IR/memory-ready into the sequencer and every datapath strobe back out.
interface alu_control_sequencer_if #(
  parameter int NREG = 16
);
  logic [31:0]     ir;
  logic            mem_ready;
  logic            PCout;
  logic            MARin;
  logic            IncPC;
  logic            Read;
  logic            MDRin;
  logic            MDRout;
  logic            IRin;
  logic            Yin;
  logic            ZLowIn;
  logic            ZHighIn;
  logic            ZLowOut;
  logic            ZHighOut;
  logic            LOin;
  logic            HIin;
  logic [NREG-1:0] Rin;
  logic [NREG-1:0] Rout;
  logic [4:0]      alu_op;
  logic            run;
  logic            illegal;

  modport master (
    input  ir, mem_ready,
    output PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin,
    output ZLowIn, ZHighIn, ZLowOut, ZHighOut, LOin, HIin,
    output Rin, Rout, alu_op, run, illegal
  );

  modport slave (
    output ir, mem_ready,
    input  PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin,
    input  ZLowIn, ZHighIn, ZLowOut, ZHighOut, LOin, HIin,
    input  Rin, Rout, alu_op, run, illegal
  );
endinterface

// File: rtl/alu_control_sequencer.sv
// Hardwired fetch/execute control unit producing T0..T6 datapath strobes from IR.
// Optional single-step gate on instruction fetch: define CU_SINGLE_STEP_EN.
module alu_control_sequencer #(
  parameter int NREG           = 16,
  parameter int FETCH_WAIT_MAX = 15
) (
  input  logic clock,
  input  logic clear,
`ifdef CU_SINGLE_STEP_EN
  input  logic step,
`endif
  alu_control_sequencer_if.master bus
);

  localparam int CW = $clog2(FETCH_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(FETCH_WAIT_MAX - 1);

  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SHL  = 5'h0B;
  localparam logic [4:0] OP_MUL  = 5'h0F;
  localparam logic [4:0] OP_DIV  = 5'h10;
  localparam logic [4:0] OP_NOP  = 5'h1A;
  localparam logic [4:0] OP_HALT = 5'h1B;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_EXEC3,
    S_EXEC4,
    S_EXEC5,
    S_EXEC6,
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          illegal_q, illegal_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_muldiv, regs_ok, exec_ok, fetch_go;
  logic       unused_ir_bits;

  assign opcode = bus.ir[31:27];
  assign ra     = bus.ir[26:23];
  assign rb     = bus.ir[22:19];
  assign rc     = bus.ir[18:15];
  assign unused_ir_bits = ^bus.ir[14:0];

  function automatic logic idx_ok(input logic [3:0] idx);
    return 32'(idx) < NREG;
  endfunction

  // mul/div never write Ra, so its index is only checked for plain ALU ops
  assign is_alu    = (opcode >= OP_ADD) && (opcode <= OP_SHL);
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign regs_ok   = idx_ok(rb) && idx_ok(rc) && (is_muldiv || idx_ok(ra));
  assign exec_ok   = (is_alu || is_muldiv) && regs_ok;

`ifdef CU_SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= S_RESET;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.run     = (state_q != S_HALT);
  assign bus.illegal = illegal_q;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    illegal_d    = illegal_q;
    bus.PCout    = 1'b0;
    bus.MARin    = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.ZLowIn   = 1'b0;
    bus.ZHighIn  = 1'b0;
    bus.ZLowOut  = 1'b0;
    bus.ZHighOut = 1'b0;
    bus.LOin     = 1'b0;
    bus.HIin     = 1'b0;
    bus.Rin      = '0;
    bus.Rout     = '0;
    bus.alu_op   = '0;

    case (state_q)
      S_RESET: state_d = S_FETCH0;

      S_FETCH0: begin
        if (fetch_go) begin
          bus.PCout  = 1'b1;
          bus.MARin  = 1'b1;
          bus.IncPC  = 1'b1;
          bus.ZLowIn = 1'b1;
          state_d    = S_FETCH1;
        end
      end

      S_FETCH1: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
        // a late mem_ready on the final allowed cycle still completes the fetch
        if (bus.mem_ready) begin
          state_d    = S_FETCH2;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = S_HALT;
          illegal_d  = 1'b1;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end

      S_FETCH2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_d    = S_EXEC3;
      end

      S_EXEC3: begin
        if (opcode == OP_NOP) begin
          state_d = S_FETCH0;
        end else if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else if (!exec_ok) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          bus.Rout = NREG'(1) << rb;
          bus.Yin  = 1'b1;
          state_d  = S_EXEC4;
        end
      end

      S_EXEC4: begin
        bus.Rout    = NREG'(1) << rc;
        bus.ZLowIn  = 1'b1;
        bus.ZHighIn = is_muldiv;
        bus.alu_op  = opcode;
        state_d     = S_EXEC5;
      end

      S_EXEC5: begin
        bus.ZLowOut = 1'b1;
        if (is_muldiv) begin
          bus.LOin = 1'b1;
          state_d  = S_EXEC6;
        end else begin
          bus.Rin  = NREG'(1) << ra;
          state_d  = S_FETCH0;
        end
      end

      S_EXEC6: begin
        bus.ZHighOut = 1'b1;
        bus.HIin     = 1'b1;
        state_d      = S_FETCH0;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Scoreboard bench: expected per-cycle strobe vectors are queued per instruction
// and popped/compared one per clock against the sequencer outputs.
module tb_alu_control_sequencer;
  localparam int NREG = 16;
  localparam int WAITMAX = 15;

  logic clock = 1'b0;
  logic clear = 1'b1;
`ifdef CU_SINGLE_STEP_EN
  logic step = 1'b1;
`endif
  bit step_pulse = 1'b0;

  alu_control_sequencer_if #(.NREG(NREG)) bus ();

  alu_control_sequencer #(.NREG(NREG), .FETCH_WAIT_MAX(WAITMAX)) dut (
    .clock (clock),
    .clear (clear),
`ifdef CU_SINGLE_STEP_EN
    .step  (step),
`endif
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic pcout, marin, incpc, read, mdrin, mdrout, irin, yin;
    logic zlowin, zhighin, zlowout, zhighout, loin, hiin;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu_op;
    logic run, illegal;
  } outs_t;

  typedef struct {
    string tag;
    outs_t v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   ill_m  = 1'b0;

  function automatic outs_t base();
    outs_t o = '0;
    o.run = 1'b1;
    o.illegal = ill_m;
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.pcout = bus.PCout;     o.marin = bus.MARin;     o.incpc = bus.IncPC;
    o.read = bus.Read;       o.mdrin = bus.MDRin;     o.mdrout = bus.MDRout;
    o.irin = bus.IRin;       o.yin = bus.Yin;         o.zlowin = bus.ZLowIn;
    o.zhighin = bus.ZHighIn; o.zlowout = bus.ZLowOut; o.zhighout = bus.ZHighOut;
    o.loin = bus.LOin;       o.hiin = bus.HIin;
    o.rin = bus.Rin;         o.rout = bus.Rout;       o.alu_op = bus.alu_op;
    o.run = bus.run;         o.illegal = bus.illegal;
    return o;
  endfunction

  task automatic push(input string tag, input outs_t v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    q.push_back(e);
  endtask

  task automatic check_cur();
    exp_t e;
    outs_t obs;
    obs = sample();
    checks++;
    assert (q.size() > 0) else begin
      errors++;
      $error("FAIL sb_empty observed=%h expected=queued_entry", obs);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic push_fetch(input int waits);
    outs_t o;
    o = base(); o.pcout = 1; o.marin = 1; o.incpc = 1; o.zlowin = 1;
    push("T0", o);
    for (int k = 0; k <= waits; k++) begin
      o = base(); o.read = 1; o.mdrin = 1;
      push("T1", o);
    end
    o = base(); o.mdrout = 1; o.irin = 1;
    push("T2", o);
  endtask

  // Expected strobe sequence straight from the instruction timing table
  task automatic push_instr(input logic [31:0] instr, input int waits);
    outs_t o;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    op = instr[31:27]; ra = instr[26:23]; rb = instr[22:19]; rc = instr[18:15];
    push_fetch(waits);
    if (op >= 5'h03 && op <= 5'h0B) begin
      o = base(); o.rout = 16'h1 << rb; o.yin = 1; push("T3_alu", o);
      o = base(); o.rout = 16'h1 << rc; o.zlowin = 1; o.alu_op = op; push("T4_alu", o);
      o = base(); o.zlowout = 1; o.rin = 16'h1 << ra; push("T5_alu", o);
    end else if (op == 5'h0F || op == 5'h10) begin
      o = base(); o.rout = 16'h1 << rb; o.yin = 1; push("T3_md", o);
      o = base(); o.rout = 16'h1 << rc; o.zlowin = 1; o.zhighin = 1; o.alu_op = op;
      push("T4_md", o);
      o = base(); o.zlowout = 1; o.loin = 1; push("T5_md", o);
      o = base(); o.zhighout = 1; o.hiin = 1; push("T6_md", o);
    end else begin
      push("T3_none", base());
      if (op != 5'h1A && op != 5'h1B) ill_m = 1'b1;
    end
  endtask

  task automatic run_instr(input logic [31:0] instr, input int waits, input int halt_cycles);
    outs_t o;
    int n;
    bus.ir = instr;
    push_instr(instr, waits);
    for (int h = 0; h < halt_cycles; h++) begin
      o = base(); o.run = 1'b0;
      push("HALT", o);
    end
    n = q.size();
    for (int i = 0; i < n; i++) begin
      check_cur();
      bus.mem_ready = (i >= waits + 1);
`ifdef CU_SINGLE_STEP_EN
      if (step_pulse && i == 1) step = 1'b0;
`endif
      adv();
    end
  endtask

  task automatic run_timeout(input int halt_cycles);
    outs_t o;
    int n;
    bus.mem_ready = 1'b0;
    o = base(); o.pcout = 1; o.marin = 1; o.incpc = 1; o.zlowin = 1;
    push("T0_to", o);
    for (int k = 0; k < WAITMAX; k++) begin
      o = base(); o.read = 1; o.mdrin = 1;
      push("T1_to", o);
    end
    ill_m = 1'b1;
    for (int h = 0; h < halt_cycles; h++) begin
      o = base(); o.run = 1'b0;
      push("HALT_to", o);
    end
    n = q.size();
    for (int i = 0; i < n; i++) begin
      check_cur();
      adv();
    end
  endtask

  task automatic do_reset();
    clear = 1'b0;
    #1;
    ill_m = 1'b0;
    push("RESET", base());
    check_cur();
    @(negedge clock);
    clear = 1'b1;
    adv();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.ir = 32'h0;
    bus.mem_ready = 1'b0;
    #1;
    do_reset();

    run_instr(32'h3A1B8000, 0, 0);   // ror R4,R3,R7
    run_instr(32'h78130000, 0, 0);   // mul R2,R6
    run_instr(32'h18000000, 3, 0);   // add R0,R0,R0 with 3 wait states
    run_instr(32'hD0000000, 0, 0);   // nop
    run_instr(32'h802C8000, WAITMAX - 1, 0);  // div, mem_ready on the last allowed cycle

    // abort ror in EXEC4 with a roughly one-clock reset pulse
    bus.ir = 32'h3A1B8000;
    bus.mem_ready = 1'b1;
    push_instr(32'h3A1B8000, 0);
    for (int i = 0; i < 4; i++) begin
      check_cur();
      adv();
    end
    check_cur();
    #3;
    clear = 1'b0;
    q.delete();
    ill_m = 1'b0;
    #1;
    push("RESET_mid", base());
    check_cur();
    adv();
    push("RESET_hold", base());
    check_cur();
    @(negedge clock);
    clear = 1'b1;
    adv();
    run_instr(32'h20918000, 0, 0);   // sub R1,R2,R3 resumes from FETCH0

    run_timeout(3);
    do_reset();
    run_instr(32'hD8000000, 0, 3);   // halt
    do_reset();
    run_instr(32'hF8000000, 0, 3);   // undefined opcode
    do_reset();
    run_instr(32'h18000000, 0, 0);   // clean add after fault recovery

`ifdef CU_SINGLE_STEP_EN
    step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push("STEP_hold", base());
      check_cur();
      adv();
    end
    step = 1'b1;
    step_pulse = 1'b1;
    run_instr(32'h18918000, 0, 0);   // add R1,R2,R3 on a single step pulse
    step_pulse = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push("STEP_after", base());
      check_cur();
      adv();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
